// File: rtl/crc4_frame_checker.sv
// Serial frame receiver: hunts for a sync word, collects a payload and a trailing
// CRC-4 (x^4+x+1, init 0), then reports the payload, the CRC result and running counts.
module crc4_frame_checker #(
  parameter int          DATA_BITS = 8,
  parameter logic [7:0]  SYNC_WORD = 8'h7E
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bit_valid,
  input  logic                 bit_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 frame_valid,
  output logic                 crc_ok,
  output logic                 busy,
  output logic [7:0]           frame_cnt,
  output logic [7:0]           err_cnt
);

  typedef enum logic [1:0] {HUNT, DATA, CHECK} state_t;

  localparam logic [5:0] LAST_DATA_BIT = 6'(DATA_BITS - 1);
  localparam logic [5:0] LAST_CRC_BIT  = 6'd3;

  state_t               state_q, state_d;
  logic [7:0]           sync_sr_q, sync_sr_d;
  logic [DATA_BITS-1:0] data_sr_q, data_sr_d;
  logic [3:0]           crc_q, crc_d;
  logic [3:0]           rx_crc_q, rx_crc_d;
  logic [5:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 frame_valid_q, frame_valid_d;
  logic                 crc_ok_q, crc_ok_d;
  logic [7:0]           frame_cnt_q, frame_cnt_d;
  logic [7:0]           err_cnt_q, err_cnt_d;

  function automatic logic [3:0] crc_next(input logic [3:0] crc, input logic b);
    logic fb;
    fb = crc[3] ^ b;
    return {crc[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    state_d       = state_q;
    sync_sr_d     = sync_sr_q;
    data_sr_d     = data_sr_q;
    crc_d         = crc_q;
    rx_crc_d      = rx_crc_q;
    bit_cnt_d     = bit_cnt_q;
    data_out_d    = data_out_q;
    frame_valid_d = 1'b0;
    crc_ok_d      = crc_ok_q;
    frame_cnt_d   = frame_cnt_q;
    err_cnt_d     = err_cnt_q;

    if (bit_valid) begin
      unique case (state_q)
        HUNT: begin
          sync_sr_d = {sync_sr_q[6:0], bit_in};
          if (sync_sr_d == SYNC_WORD) begin
            state_d   = DATA;
            bit_cnt_d = '0;
            crc_d     = 4'b0000;
          end
        end
        DATA: begin
          data_sr_d = (data_sr_q << 1) | DATA_BITS'(bit_in);
          crc_d     = crc_next(crc_q, bit_in);
          if (bit_cnt_q == LAST_DATA_BIT) begin
            state_d   = CHECK;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
        end
        CHECK: begin
          rx_crc_d = {rx_crc_q[2:0], bit_in};
          if (bit_cnt_q == LAST_CRC_BIT) begin
            // Frame complete: publish result and restart the sync search from scratch,
            // so payload/CRC bits can never contribute to a false sync.
            data_out_d    = data_sr_q;
            crc_ok_d      = (rx_crc_d == crc_q);
            frame_valid_d = 1'b1;
            frame_cnt_d   = sat_inc(frame_cnt_q);
            if (rx_crc_d != crc_q) err_cnt_d = sat_inc(err_cnt_q);
            state_d   = HUNT;
            sync_sr_d = 8'h00;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= HUNT;
      sync_sr_q     <= '0;
      data_sr_q     <= '0;
      crc_q         <= '0;
      rx_crc_q      <= '0;
      bit_cnt_q     <= '0;
      data_out_q    <= '0;
      frame_valid_q <= 1'b0;
      crc_ok_q      <= 1'b0;
      frame_cnt_q   <= '0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      sync_sr_q     <= sync_sr_d;
      data_sr_q     <= data_sr_d;
      crc_q         <= crc_d;
      rx_crc_q      <= rx_crc_d;
      bit_cnt_q     <= bit_cnt_d;
      data_out_q    <= data_out_d;
      frame_valid_q <= frame_valid_d;
      crc_ok_q      <= crc_ok_d;
      frame_cnt_q   <= frame_cnt_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign data_out    = data_out_q;
  assign frame_valid = frame_valid_q;
  assign crc_ok      = crc_ok_q;
  assign busy        = (state_q != HUNT);
  assign frame_cnt   = frame_cnt_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_crc4_frame_checker.sv
// Directed plus randomized bench for crc4_frame_checker; a bit-stream frame decoder
// with a long-division CRC reference predicts every output on every cycle.
module tb_crc4_frame_checker;

  localparam int         DB   = 8;
  localparam logic [7:0] SYNC = 8'h7E;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          bit_valid = 1'b0;
  logic          bit_in = 1'b0;
  logic [DB-1:0] data_out;
  logic          frame_valid;
  logic          crc_ok;
  logic          busy;
  logic [7:0]    frame_cnt;
  logic [7:0]    err_cnt;

  crc4_frame_checker #(.DATA_BITS(DB), .SYNC_WORD(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_in(bit_in),
    .data_out(data_out), .frame_valid(frame_valid), .crc_ok(crc_ok),
    .busy(busy), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int pulses = 0;

  // Reference model state: frame decoder over the accepted bit stream
  logic          m_hunt;
  logic [7:0]    m_win;
  logic [39:0]   m_rx;
  int            m_nrx;
  logic          exp_fv;
  logic [DB-1:0] exp_data;
  logic          exp_ok;
  int            exp_fcnt;
  int            exp_ecnt;

  // CRC as the remainder of payload*x^4 divided by x^4+x+1 over GF(2)
  function automatic logic [3:0] crc4_ref(input logic [31:0] payload, input int n);
    logic [39:0] v;
    v = 40'(payload) << 4;
    for (int i = n + 3; i >= 4; i--)
      if (v[i]) v = v ^ (40'h13 << (i - 4));
    return v[3:0];
  endfunction

  task automatic model_reset();
    m_hunt = 1'b1; m_win = 8'h00; m_rx = '0; m_nrx = 0;
    exp_fv = 1'b0; exp_data = '0; exp_ok = 1'b0; exp_fcnt = 0; exp_ecnt = 0;
  endtask

  task automatic model_step(input logic v, input logic b);
    logic [31:0] pl;
    logic [3:0]  rcrc;
    exp_fv = 1'b0;
    if (!v) return;
    if (m_hunt) begin
      m_win = {m_win[6:0], b};
      if (m_win == SYNC) begin
        m_hunt = 1'b0; m_rx = '0; m_nrx = 0;
      end
    end else begin
      m_rx = {m_rx[38:0], b};
      m_nrx++;
      if (m_nrx == DB + 4) begin
        pl       = 32'(m_rx >> 4);
        rcrc     = m_rx[3:0];
        exp_data = DB'(pl);
        exp_ok   = (rcrc == crc4_ref(pl, DB));
        exp_fv   = 1'b1;
        if (exp_fcnt < 255) exp_fcnt++;
        if (!exp_ok && exp_ecnt < 255) exp_ecnt++;
        m_hunt = 1'b1; m_win = 8'h00;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    if (frame_valid === 1'b1) pulses++;
    chk({tag, ".frame_valid"}, 32'(frame_valid), 32'(exp_fv));
    chk({tag, ".busy"},        32'(busy),        32'(!m_hunt));
    chk({tag, ".data_out"},    32'(data_out),    32'(exp_data));
    chk({tag, ".crc_ok"},      32'(crc_ok),      32'(exp_ok));
    chk({tag, ".frame_cnt"},   32'(frame_cnt),   32'(exp_fcnt));
    chk({tag, ".err_cnt"},     32'(err_cnt),     32'(exp_ecnt));
  endtask

  task automatic cycle(input logic v, input logic b, input string tag);
    @(negedge clk);
    bit_valid = v;
    bit_in    = b;
    @(posedge clk);
    model_step(v, b);
    #1;
    check_all(tag);
  endtask

  task automatic send_bit(input logic b, input int maxgap, input string tag);
    int gap;
    gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
    for (int g = 0; g < gap; g++) cycle(1'b0, 1'b0, tag);
    cycle(1'b1, b, tag);
  endtask

  task automatic send_word(input logic [39:0] w, input int n, input int maxgap, input string tag);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i], maxgap, tag);
  endtask

  task automatic send_frame(input logic [31:0] pl, input logic [3:0] c, input int maxgap,
                            input string tag);
    send_word(40'(SYNC), 8, maxgap, tag);
    send_word(40'(pl), DB, maxgap, tag);
    send_word(40'(c), 4, maxgap, tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    bit_valid = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [31:0] pl;
    logic [3:0]  c;
    logic        b;

    model_reset();
    #3;
    check_all("reset0");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, "idle");

    // Known-good frame: payload 0x80 carries CRC 1110
    send_frame(32'h80, 4'b1110, 0, "f80");
    cycle(1'b0, 1'b0, "f80.after");
    chk("f80.data_out", 32'(data_out), 32'h80);
    chk("f80.crc_ok", 32'(crc_ok), 32'd1);
    chk("f80.counts", {24'd0, frame_cnt, err_cnt} >> 0, 32'h0100);

    // Payload 0x01 with a deliberately wrong CRC (correct is 0011)
    send_frame(32'h01, 4'b0010, 0, "f01bad");
    cycle(1'b0, 1'b0, "f01bad.after");
    chk("f01bad.crc_ok", 32'(crc_ok), 32'd0);
    chk("f01bad.err_cnt", 32'(err_cnt), 32'd1);
    chk("f01bad.data_out", 32'(data_out), 32'h01);

    // Random noise free of the sync pattern, then a zero frame with random gaps
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      b = 1'($urandom_range(1, 0));
      if ({m_win[6:0], b} == SYNC) b = ~b;
      send_bit(b, 5, "noise");
    end
    send_word(40'h0, 8, 5, "noise.zeros");
    chk("noise.no_frame", 32'(pulses), 32'd0);
    send_frame(32'h00, 4'b0000, 5, "fzero");
    cycle(1'b0, 1'b0, "fzero.after");
    chk("fzero.pulses", 32'(pulses), 32'd1);
    chk("fzero.data_out", 32'(data_out), 32'h00);
    chk("fzero.crc_ok", 32'(crc_ok), 32'd1);

    // Payload equal to the sync word, then a second frame, back to back
    pulses = 0;
    send_frame(32'(SYNC), crc4_ref(32'(SYNC), DB), 0, "f7e");
    pl = $urandom_range(255, 0);
    send_frame(pl, crc4_ref(pl, DB), 0, "b2b");
    cycle(1'b0, 1'b0, "b2b.after");
    chk("b2b.pulses", 32'(pulses), 32'd2);

    // Reset in the middle of a payload discards the partial frame
    pulses = 0;
    send_word(40'(SYNC), 8, 0, "midrst");
    send_word(40'hA, 4, 0, "midrst");
    do_reset("midrst.reset");
    chk("midrst.busy", 32'(busy), 32'd0);
    pl = 32'h5A;
    send_frame(pl, crc4_ref(pl, DB), 2, "postrst");
    cycle(1'b0, 1'b0, "postrst.after");
    chk("postrst.pulses", 32'(pulses), 32'd1);
    chk("postrst.frame_cnt", 32'(frame_cnt), 32'd1);
    chk("postrst.err_cnt", 32'(err_cnt), 32'd0);

    // Random frames, random CRC corruption, random gaps
    for (int f = 0; f < 20; f++) begin
      pl = $urandom_range(255, 0);
      c  = crc4_ref(pl, DB);
      if ($urandom_range(3, 0) == 0) c = c ^ 4'(1 + $urandom_range(14, 0));
      send_frame(pl, c, $urandom_range(3, 0), "rand");
    end

    // Counter saturation with 260 bad frames
    do_reset("sat.reset");
    for (int f = 0; f < 260; f++) begin
      pl = $urandom_range(255, 0);
      send_frame(pl, crc4_ref(pl, DB) ^ 4'b1000, 0, "sat");
    end
    cycle(1'b0, 1'b0, "sat.after");
    chk("sat.frame_cnt", 32'(frame_cnt), 32'hFF);
    chk("sat.err_cnt", 32'(err_cnt), 32'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/crc4_frame_checker.md
CRC4_FRAME_CHECKER -- requirements
Module: crc4_frame_checker

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8: payload bits per frame, legal range 1..32.
REQ-002 SHALL have parameter SYNC_WORD, default 8'h7E: 8-bit frame sync pattern, compared MSB-first.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port bit_valid, input, 1: strobe, one cycle per demodulated symbol.
REQ-006 SHALL have port bit_in, input, 1: demodulated symbol from the FSK demodulator sign output; sampled only when bit_valid=1.
REQ-007 SHALL have port data_out, output, DATA_BITS: last received payload, first-received bit in MSB.
REQ-008 SHALL have port frame_valid, output, 1: one-cycle pulse per completed frame.
REQ-009 SHALL have port crc_ok, output, 1: result of the last completed frame; 1 means CRC match.
REQ-010 SHALL have port busy, output, 1: high in every state except HUNT.
REQ-011 SHALL have port frame_cnt, output, 8: count of completed frames, saturating.
REQ-012 SHALL have port err_cnt, output, 8: count of frames with CRC mismatch, saturating.

Function
REQ-013 SHALL implement states HUNT, DATA, CHECK; all state advances occur only on cycles with bit_valid=1.
REQ-014 HUNT: SHALL shift bit_in into the 8-bit sync_sr LSB; when the post-shift value equals SYNC_WORD, SHALL go to DATA, clear bit_cnt, and clear crc to 4'b0000.
REQ-015 DATA: SHALL shift bit_in into data_sr LSB and update crc; after DATA_BITS bits, SHALL go to CHECK with bit_cnt cleared.
REQ-016 CRC update per data bit: fb = crc[3]^bit_in; crc_next = {crc[2:0],1'b0} ^ (fb ? 4'b0011 : 4'b0000). This is polynomial x^4+x+1, init 0, no reflection, no final XOR.
REQ-017 CHECK: SHALL shift 4 received CRC bits MSB-first into rx_crc.
REQ-018 On the edge that samples the 4th CRC bit, SHALL load data_out<=data_sr, crc_ok<=(rx_crc_final==crc), and frame_valid<=1; the outputs are visible the following cycle.
REQ-019 On the same edge, SHALL increment frame_cnt and increment err_cnt on mismatch, then return to HUNT with sync_sr cleared to 8'h00.
REQ-020 frame_valid SHALL deassert on the next clock edge regardless of bit_valid.
REQ-021 data_out and crc_ok SHALL hold their values until the next frame completes.
REQ-022 bit_valid may be held high continuously; the block SHALL accept one bit per cycle with no stall.
REQ-023 Idle cycles (bit_valid=0) mid-frame SHALL preserve all state with no timeout.
REQ-024 Payload or CRC bits SHALL NOT be compared against SYNC_WORD; sync search resumes only in HUNT, from a cleared sync_sr.
REQ-025 frame_cnt and err_cnt SHALL saturate at 8'hFF and not wrap.

Reset
REQ-026 While rst_n=0, SHALL force state=HUNT, sync_sr=0, data_sr=0, crc=0, rx_crc=0, bit_cnt=0, data_out=0, frame_valid=0, crc_ok=0, busy=0, frame_cnt=0, err_cnt=0, asynchronously.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame without emitting frame_valid; the first bit_valid after release is treated as a HUNT bit.

Verification
REQ-028 Send 0x7E, payload 0x80, CRC 1110 -> one frame_valid pulse, data_out=8'h80, crc_ok=1, frame_cnt=1, err_cnt=0.
REQ-029 Send 0x7E, payload 0x01, CRC 0010 (correct value 0011) -> frame_valid, crc_ok=0, err_cnt=1.
REQ-030 Send random bits not containing 0x7E, then 0x7E, 0x00, 0000 with bit_valid gaps of 0-5 cycles -> exactly one frame, data_out=0, crc_ok=1, busy high from the sync match until frame end.
REQ-031 Send a payload equal to 0x7E, followed by two consecutive frames with bit_valid held continuously high -> exactly two frame_valid pulses; the payload 0x7E is not taken as sync.
REQ-032 Pulse rst_n low after 4 payload bits, then send a full valid frame -> no pulse before reset, exactly one valid frame after, counters=1/0.
REQ-033 Send 260 frames with bad CRC -> frame_cnt=err_cnt=8'hFF, with no wrap.
